// File: rtl/daq_frame_gen.sv
// -----------------------------------------------------------------------------
// daq_frame_gen
//
// DAQ test-frame source for the capture FIFO behind /dev/xillybus_read_32.
// Each frame is one head word, PAYLOAD_WORDS payload words and one tail word.
//   head    = HEAD ^ channel index (zero-extended)
//   payload = {row+1, row+2}, two DATA_W/2 halves; row starts at 0 each frame
//             and steps by 2 per payload word
//   tail    = TAIL
// Writes are paced: after a write, the next one waits pace_div more cycles.
// If the FIFO goes full after it has been seen non-full, the overflow flag
// latches and the generator parks in HALT, so the host read path can see EOF.
//
// Optional feature macro: DAQ_FRAME_GEN_TAIL_COUNT_EN
//   defined   : tail = {TAIL[DATA_W-1:16], frame_count[15:0]}, where the
//               count is the value before this tail's increment
//   undefined : tail = TAIL
//
// Ports
//   bus_clk        in   clock for all logic
//   srst           in   synchronous reset, active high
//   cfg_cmd        in   command byte: FF start, C0 reset, C7 close
//   cfg_cmd_valid  in   cfg_cmd qualifier
//   pace_div       in   minimum write spacing is pace_div+1 cycles
//   open           in   consumer open flag (already in bus_clk domain)
//   fifo_full      in   capture FIFO full
//   fifo_wr_en     out  FIFO write strobe (combinational)
//   fifo_din       out  current word (registered)
//   overflow       out  sticky: FIFO full after having been non-full
//   frame_count    out  completed frames (tail writes), wraps
//   busy           out  state is not IDLE
//   led_active     out  fifo_wr_en delayed by one cycle
// -----------------------------------------------------------------------------
module daq_frame_gen #(
  parameter int          DATA_W        = 32,
  parameter int          PAYLOAD_WORDS = 24,
  parameter int          NUM_CH        = 1,
  parameter int          PACE_W        = 5,
  parameter logic [31:0] HEAD          = 32'hAAAAAAAA,
  parameter logic [31:0] TAIL          = 32'hF0F0F0F0
) (
  input  logic              bus_clk,
  input  logic              srst,
  input  logic [7:0]        cfg_cmd,
  input  logic              cfg_cmd_valid,
  input  logic [PACE_W-1:0] pace_div,
  input  logic              open,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic              overflow,
  output logic [31:0]       frame_count,
  output logic              busy,
  output logic              led_active
);

  localparam int HALF_W = DATA_W / 2;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WC_W   = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;

  localparam logic [DATA_W-1:0] HEAD_PAT  = DATA_W'(HEAD);
  localparam logic [DATA_W-1:0] TAIL_PAT  = DATA_W'(TAIL);
  localparam logic [WC_W-1:0]   LAST_WORD = WC_W'(PAYLOAD_WORDS - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

  localparam logic [7:0] CMD_START = 8'hFF;
  localparam logic [7:0] CMD_RESET = 8'hC0;
  localparam logic [7:0] CMD_CLOSE = 8'hC7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEAD    = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_TAIL    = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic [PACE_W-1:0]   pace_cnt_reg, pace_next;
  logic [HALF_W-1:0]   row_reg, row_next;
  logic [WC_W-1:0]     word_cnt_reg, word_cnt_next;
  logic [CH_W-1:0]     ch_reg, ch_next;
  logic                close_pend_reg, close_pend_next;
  logic                nonfull_seen_reg, nonfull_seen_next;
  logic                overflow_reg, overflow_next;
  logic [31:0]         frame_count_reg, frame_count_next;
  logic [DATA_W-1:0]   fifo_din_reg, din_next;
  logic                led_active_reg;

  logic                streaming;
  logic                cmd_start, cmd_reset, cmd_close;
  logic [DATA_W-1:0]   head_word, payload_word, tail_word;

  assign cmd_start = cfg_cmd_valid && (cfg_cmd == CMD_START);
  assign cmd_reset = cfg_cmd_valid && (cfg_cmd == CMD_RESET);
  assign cmd_close = cfg_cmd_valid && (cfg_cmd == CMD_CLOSE);

  assign streaming = (state_reg == ST_HEAD) || (state_reg == ST_PAYLOAD) ||
                     (state_reg == ST_TAIL);

  // Full gates the strobe directly, so no word is ever offered to a full FIFO.
  assign fifo_wr_en = streaming && open && !fifo_full && (pace_cnt_reg == '0);

  assign fifo_din    = fifo_din_reg;
  assign overflow    = overflow_reg;
  assign frame_count = frame_count_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign led_active  = led_active_reg;

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: reset command / open low, then overflow, then
  // start / close, then the normal word-by-word advance.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    row_next          = row_reg;
    word_cnt_next     = word_cnt_reg;
    ch_next           = ch_reg;
    close_pend_next   = close_pend_reg;
    overflow_next     = overflow_reg;
    frame_count_next  = frame_count_reg;
    nonfull_seen_next = nonfull_seen_reg | ~fifo_full;

    // pace_div is captured at the write, so a mid-frame change applies to
    // the spacing after the next write.
    if (fifo_wr_en) begin
      pace_next = pace_div;
    end else if (pace_cnt_reg != '0) begin
      pace_next = pace_cnt_reg - 1'b1;
    end else begin
      pace_next = pace_cnt_reg;
    end

    if (cmd_reset || !open) begin
      state_next        = ST_IDLE;
      overflow_next     = 1'b0;
      nonfull_seen_next = 1'b0;
      close_pend_next   = 1'b0;
      row_next          = '0;
      word_cnt_next     = '0;
      ch_next           = '0;
      if (cmd_reset) begin
        frame_count_next = '0;
      end
    end else if (streaming && fifo_full && nonfull_seen_reg) begin
      // A full that follows a non-full is a real overflow. A full that has
      // never been non-full is the FIFO's own full-after-reset: just wait.
      overflow_next = 1'b1;
      state_next    = ST_HALT;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_start) begin
            state_next      = ST_HEAD;
            row_next        = '0;
            word_cnt_next   = '0;
            pace_next       = '0;
            close_pend_next = 1'b0;
          end
        end
        ST_HALT: begin
          if (cmd_close) begin
            state_next = ST_IDLE;
          end
        end
        ST_HEAD, ST_PAYLOAD, ST_TAIL: begin
          // Close never truncates a frame; it is acted on at the tail write.
          if (cmd_close) begin
            close_pend_next = 1'b1;
          end
          if (fifo_wr_en) begin
            case (state_reg)
              ST_HEAD: begin
                state_next = ST_PAYLOAD;
              end
              ST_PAYLOAD: begin
                row_next = row_reg + HALF_W'(2);
                if (word_cnt_reg == LAST_WORD) begin
                  word_cnt_next = '0;
                  state_next    = ST_TAIL;
                end else begin
                  word_cnt_next = word_cnt_reg + 1'b1;
                end
              end
              ST_TAIL: begin
                frame_count_next = frame_count_reg + 32'd1;
                ch_next          = (ch_reg == LAST_CH) ? '0 : ch_reg + 1'b1;
                row_next         = '0;
                word_cnt_next    = '0;
                if (close_pend_next) begin
                  state_next      = ST_IDLE;
                  close_pend_next = 1'b0;
                end else begin
                  state_next = ST_HEAD;
                end
              end
              default: begin
              end
            endcase
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Word formation. fifo_din is loaded with the word belonging to the state
  // being entered, so it is ready in the same cycle the state presents it.
  // ---------------------------------------------------------------------------
  assign head_word    = HEAD_PAT ^ DATA_W'(ch_next);
  assign payload_word = {row_next + HALF_W'(1), row_next + HALF_W'(2)};

`ifdef DAQ_FRAME_GEN_TAIL_COUNT_EN
  // frame_count_next still holds the pre-increment count while in TAIL.
  if (DATA_W > 16) begin : g_tail_hi
    assign tail_word = {TAIL_PAT[DATA_W-1:16], frame_count_next[15:0]};
  end else begin : g_tail_lo
    assign tail_word = frame_count_next[15:0];
  end
`else
  assign tail_word = TAIL_PAT;
`endif

  always_comb begin
    din_next = fifo_din_reg;
    case (state_next)
      ST_HEAD:    din_next = head_word;
      ST_PAYLOAD: din_next = payload_word;
      ST_TAIL:    din_next = tail_word;
      default:    din_next = fifo_din_reg;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge bus_clk) begin
    if (srst) begin
      state_reg        <= ST_IDLE;
      pace_cnt_reg     <= '0;
      row_reg          <= '0;
      word_cnt_reg     <= '0;
      ch_reg           <= '0;
      close_pend_reg   <= 1'b0;
      nonfull_seen_reg <= 1'b0;
      overflow_reg     <= 1'b0;
      frame_count_reg  <= '0;
      fifo_din_reg     <= '0;
      led_active_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      pace_cnt_reg     <= pace_next;
      row_reg          <= row_next;
      word_cnt_reg     <= word_cnt_next;
      ch_reg           <= ch_next;
      close_pend_reg   <= close_pend_next;
      nonfull_seen_reg <= nonfull_seen_next;
      overflow_reg     <= overflow_next;
      frame_count_reg  <= frame_count_next;
      fifo_din_reg     <= din_next;
      led_active_reg   <= fifo_wr_en;
    end
  end

endmodule

// File: tb/tb_daq_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_daq_frame_gen
//
// Scoreboard bench for daq_frame_gen (NUM_CH=4, 24 payload words, 32 bits).
// A reference model follows the command/open/full inputs and, whenever a frame
// begins, pushes that frame's words (computed from the frame rules) into a
// queue. The monitor pops on every write strobe and compares. It also checks
// the write strobe against the pacing rule and the status outputs each cycle.
// -----------------------------------------------------------------------------
module tb_daq_frame_gen;

  localparam int DATA_W = 32;
  localparam int P      = 24;
  localparam int NCH    = 4;
  localparam int PACE_W = 5;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic              bus_clk = 1'b0;
  logic              srst = 1'b1;
  logic [7:0]        cfg_cmd = 8'h00;
  logic              cfg_cmd_valid = 1'b0;
  logic [PACE_W-1:0] pace_div = '0;
  logic              open = 1'b1;
  logic              fifo_full = 1'b0;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_din;
  logic              overflow;
  logic [31:0]       frame_count;
  logic              busy;
  logic              led_active;

  daq_frame_gen #(
    .DATA_W(DATA_W), .PAYLOAD_WORDS(P), .NUM_CH(NCH), .PACE_W(PACE_W),
    .HEAD(32'hAAAAAAAA), .TAIL(32'hF0F0F0F0)
  ) dut (
    .bus_clk(bus_clk), .srst(srst), .cfg_cmd(cfg_cmd),
    .cfg_cmd_valid(cfg_cmd_valid), .pace_div(pace_div), .open(open),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .overflow(overflow), .frame_count(frame_count), .busy(busy),
    .led_active(led_active)
  );

  always #5 bus_clk = ~bus_clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] exp_q[$];
  int          m_mode = M_IDLE;
  int          m_ch = 0;
  int          m_idx = 0;
  logic [31:0] m_fc = 0;
  bit          m_close = 0;
  bit          m_ovf = 0;
  bit          m_nonfull = 0;
  int          since = 1000;
  int          need = 0;
  bit          exp_wr = 0;
  bit          prev_exp = 0;
  int          nwr = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  // Word k of a frame: 0 = head, 1..P = payload, P+1 = tail.
  function automatic logic [31:0] frame_word(input int k, input int ch, input logic [31:0] fc);
    logic [31:0] w;
    if (k == 0) begin
      w = 32'hAAAAAAAA ^ 32'(ch);
    end else if (k <= P) begin
      w = {16'(2 * (k - 1) + 1), 16'(2 * (k - 1) + 2)};
    end else begin
`ifdef DAQ_FRAME_GEN_TAIL_COUNT_EN
      w = {16'hF0F0, fc[15:0]};
`else
      w = 32'hF0F0F0F0;
`endif
    end
    return w;
  endfunction

  task automatic push_frame();
    for (int k = 0; k < P + 2; k++) exp_q.push_back(frame_word(k, m_ch, m_fc));
  endtask

  // ---------------------------------------------------------------------------
  // Monitor + model: samples 3 time units after each negedge (inputs settled,
  // well away from the rising edge).
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] w;
    bit rst_c, start_c, close_c, nonfull_old;
    forever begin
      @(negedge bus_clk);
      #3;
      if (srst) begin
        exp_q.delete();
        m_mode = M_IDLE; m_ch = 0; m_idx = 0; m_fc = 0; m_close = 0;
        m_ovf = 0; m_nonfull = 0; since = 1000; need = 0; exp_wr = 0;
      end else begin
        exp_wr = (m_mode == M_RUN) && open && !fifo_full && (since >= need);
        chk("wr_en", 32'(fifo_wr_en), 32'(exp_wr));
        if (fifo_wr_en && exp_wr) begin
          nwr++;
          if (exp_q.size() == 0) begin
            chk("din_unexpected", fifo_din, 32'hDEADBEEF);
          end else begin
            w = exp_q.pop_front();
            $display("wr %0d din=%08h exp=%08h fc=%0d", nwr, fifo_din, w, m_fc);
            chk("din", fifo_din, w);
          end
        end
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
        chk("frame_count", frame_count, m_fc);
        chk("led_active", 32'(led_active), 32'(prev_exp));

        // advance the model to the next cycle
        if (exp_wr) begin
          since = 1;
          need  = int'(pace_div) + 1;
        end else if (since < 1000) begin
          since++;
        end
        rst_c   = cfg_cmd_valid && (cfg_cmd == 8'hC0);
        start_c = cfg_cmd_valid && (cfg_cmd == 8'hFF);
        close_c = cfg_cmd_valid && (cfg_cmd == 8'hC7);
        nonfull_old = m_nonfull;
        m_nonfull = m_nonfull | !fifo_full;
        if (rst_c || !open) begin
          m_mode = M_IDLE; m_ovf = 0; m_nonfull = 0; m_close = 0;
          exp_q.delete(); m_idx = 0; m_ch = 0;
          if (rst_c) m_fc = 0;
        end else if (m_mode == M_RUN && fifo_full && nonfull_old) begin
          m_ovf = 1; m_mode = M_HALT; exp_q.delete();
        end else if (m_mode == M_IDLE) begin
          if (start_c) begin
            m_mode = M_RUN; m_idx = 0; need = 0; m_close = 0;
            exp_q.delete(); push_frame();
          end
        end else if (m_mode == M_HALT) begin
          if (close_c) m_mode = M_IDLE;
        end else begin
          if (close_c) m_close = 1;
          if (exp_wr) begin
            m_idx++;
            if (m_idx == P + 2) begin
              m_idx = 0;
              m_fc  = m_fc + 1;
              m_ch  = (m_ch + 1) % NCH;
              if (m_close) begin
                m_close = 0; m_mode = M_IDLE;
              end else begin
                push_frame();
              end
            end
          end
        end
      end
      prev_exp = srst ? 1'b0 : exp_wr;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus (all driving at negedge)
  // ---------------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) @(negedge bus_clk);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cfg_cmd = c;
    cfg_cmd_valid = 1'b1;
    @(negedge bus_clk);
    cfg_cmd_valid = 1'b0;
    cfg_cmd = 8'($urandom);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge bus_clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    cycles(4);
    srst = 1'b0;
    @(negedge bus_clk);
    #4;
    chk("reset_din", fifo_din, 32'h0);
    @(negedge bus_clk);

    // back-to-back frames, one write per cycle
    send_cmd(8'hFF);
    cycles(3 * (P + 2) + 5);

    // slow pacing, then a mid-frame change
    pace_div = 5'd31;
    cycles(32 * 30);
    pace_div = 5'd3;
    cycles(200);
    pace_div = 5'd0;
    cycles(10);

    // close: frame completes through its tail
    send_cmd(8'hC7);
    wait_idle(200);

    // reset command mid-frame
    send_cmd(8'hFF);
    cycles(4);
    send_cmd(8'hC0);
    cycles(3);

    // FIFO full from the start, then drops; later a real overflow
    fifo_full = 1'b1;
    open = 1'b0;
    cycles(2);
    open = 1'b1;
    cycles(2);
    send_cmd(8'hFF);
    cycles(10);
    fifo_full = 1'b0;
    cycles(6);
    fifo_full = 1'b1;
    cycles(6);
    open = 1'b0;
    cycles(2);
    open = 1'b1;
    fifo_full = 1'b0;
    cycles(2);

    // overflow then close from HALT
    send_cmd(8'hFF);
    cycles(9);
    fifo_full = 1'b1;
    cycles(3);
    send_cmd(8'hC7);
    fifo_full = 1'b0;
    cycles(3);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cfg_cmd_valid = 1'b0;
      cfg_cmd = 8'($urandom);
      if ($urandom_range(0, 999) < 25) begin
        k = $urandom_range(0, 19);
        cfg_cmd_valid = 1'b1;
        if (k < 10)      cfg_cmd = 8'hFF;
        else if (k < 13) cfg_cmd = 8'hC7;
        else if (k < 15) cfg_cmd = 8'hC0;
      end
      if ($urandom_range(0, 29) == 0) fifo_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) open = 1'b0;
      else open = 1'b1;
      if ($urandom_range(0, 149) == 0) pace_div = 5'($urandom_range(0, 6));
      @(negedge bus_clk);
    end

    // drain to idle
    cfg_cmd_valid = 1'b0;
    fifo_full = 1'b0;
    open = 1'b1;
    pace_div = 5'd0;
    cycles(2);
    send_cmd(8'hC7);
    wait_idle(300);
    cycles(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/daq_frame_gen.md
# daq_frame_gen

Parametrised DAQ test-frame source feeding the capture FIFO of the `/dev/xillybus_read_32` path. It emits framed words: a head word, a configurable number of payload words carrying a row-counter pattern, then a tail word. Emission is paced by a runtime divider and controlled by the 8-bit configuration commands start, reset and close. A sticky overflow latch halts the stream so the host read path can signal EOF. Multi-channel rotation tags each frame's head word with a channel index.

## Interface
- DATA_W, 32: output word width; even, ≥ 16.
- PAYLOAD_WORDS, 24: payload words per frame; ≥ 1.
- NUM_CH, 1: channels rotated frame by frame; 1..256.
- PACE_W, 5: width of `pace_div`.
- HEAD, 32'hAAAAAAAA: head pattern (low DATA_W bits).
- TAIL, 32'hF0F0F0F0: tail pattern (low DATA_W bits).

Ports:
- bus_clk  in  1  Clock for all logic.
- srst  in  1  Synchronous reset, active-high.
- cfg_cmd  in  8  Command byte: 0xFF start, 0xC0 reset, 0xC7 close. Any other value is ignored.
- cfg_cmd_valid  in  1  `cfg_cmd` is sampled when this is high.
- pace_div  in  PACE_W  Minimum spacing between writes is `pace_div`+1 cycles.
- open  in  1  Consumer open flag, already synchronised to bus_clk.
- fifo_full  in  1  Capture FIFO full.
- fifo_wr_en  out  1  FIFO write strobe (combinational).
- fifo_din  out  DATA_W  Current word (registered).
- overflow  out  1  Sticky flag: FIFO was full after having been non-full.
- frame_count  out  32  Count of completed frames (tail words written); wraps.
- busy  out  1  State is not IDLE.
- led_active  out  1  Registered copy of `fifo_wr_en`, for the activity LED.

## Operation
- States:
  - IDLE, HEAD, PAYLOAD, TAIL, HALT.
  - `fifo_wr_en` = (state ∈ {HEAD, PAYLOAD, TAIL}) & `open` & !`fifo_full` & (`pace_cnt` == 0).
- Transitions on a write:
  - HEAD → PAYLOAD.
  - PAYLOAD → PAYLOAD until payload word `PAYLOAD_WORDS`-1 is written, then → TAIL.
  - TAIL → HEAD, or → IDLE if a close is pending. `frame_count` increments.
- Start (IDLE only) → HEAD. Row counter, word counter and `pace_cnt` are cleared. Start is ignored in every other state.
- Close:
  - HEAD/PAYLOAD/TAIL: sets `close_pend`; the current frame completes through its tail.
  - HALT: → IDLE.
  - IDLE: ignored.
- Reset command, or `open` low, from any state:
  - → IDLE.
  - Clears `overflow`, `nonfull_seen`, `close_pend`, row, word and channel counters.
  - The reset command also clears `frame_count`; `open` low does not.
- Word contents:
  - Head = HEAD XOR (channel index, zero-extended).
  - Payload = {row+1, row+2}, each half DATA_W/2 bits, modulo 2^(DATA_W/2). The row counter starts at 0 each frame and advances by 2 per payload word.
  - Tail = TAIL.
- Channel index advances modulo NUM_CH after each tail write.
- Overflow:
  - `nonfull_seen` is set whenever `fifo_full` is low.
  - `fifo_full` & `nonfull_seen` while in HEAD/PAYLOAD/TAIL → `overflow` set, state → HALT, no further writes.
  - While `fifo_full` is high and `nonfull_seen` is low (FIFO's full-after-reset), the current word is held and the state does not advance.
- Priority: `srst` > reset command / `open` low > overflow > close/start > normal advance.

## Timing
- Reset values:
  - `fifo_wr_en`: follows its combinational equation (0 in IDLE).
  - `fifo_din` = 0.
  - `overflow`, `busy`, `led_active` = 0.
  - `frame_count` = 0.
  - state = IDLE.
- Start sampled at cycle N → state HEAD and `fifo_din` = head word at N+1 → `fifo_wr_en` high at N+1 if not blocked.
- Pace counter:
  - On each write, `pace_cnt` ← `pace_div` (sampled at that write).
  - Otherwise it decrements while non-zero.
  - `pace_div` = 0 gives one write per cycle.
- `fifo_din` updates on the cycle after each write to the next word; it is held while stalled.
- Frame length is `PAYLOAD_WORDS`+2 writes; there is no gap between frames beyond pacing.
- Overflow: `fifo_full` sampled at cycle M → `overflow` = 1 and state HALT at M+1. `fifo_wr_en` is already 0 at M because full gates it.
- `led_active` = `fifo_wr_en` delayed by 1 cycle.

## Configuration
- `DAQ_FRAME_GEN_TAIL_COUNT_EN`:
  - Defined: tail = {TAIL[DATA_W-1:16], `frame_count`[15:0]}, using the value before the increment. The first frame's tail carries 0.
  - Undefined: tail = TAIL exactly, and no extra mux is built.

## Test plan
- Default parameters, `pace_div`=0, open=1, start: write sequence is AAAAAAAA, 00010002, 00030004, …, 002F0030 (24th payload word), F0F0F0F0, then AAAAAAAA again; one write per cycle; `frame_count`=1 after the first tail.
- `pace_div`=31, start: consecutive `fifo_wr_en` pulses exactly 32 cycles apart; `pace_div` changed to 3 mid-frame → spacing becomes 4 after the next write.
- FIFO initially full (`nonfull_seen`=0), then it drops: no overflow and the first write is AAAAAAAA. Later, `fifo_full` raised after payload word 5 → `overflow`=1 and HALT with no further writes. Drop `open` → `overflow`=0, `busy`=0.
- Close sampled during payload word 10: the frame finishes through F0F0F0F0, then IDLE; `frame_count`=1. A reset command at the 3rd payload word instead → IDLE next cycle and `frame_count`=0.
- NUM_CH=4: successive head words are AAAAAAAA, AAAAAAAB, AAAAAAA8, AAAAAAA9, AAAAAAAA.
- With `DAQ_FRAME_GEN_TAIL_COUNT_EN` defined: tails of frames 1–3 are F0F00000, F0F00001, F0F00002. With it undefined, all tails are F0F0F0F0.
